cordic_exp_ctrl: RTL and testbench

Sequencer for the CORDIC exponential datapath. Accepts a start request, loads the initial X/Y/Z operands, then steps the arctanh ROM address through every iteration with one-cycle prefetch, so that each ROM word arrives in the same cycle as its iteration-enable. Captures the result and holds a ready flag until it is acknowledged. Sits between the top-level handshake and the datapath registers and ROM.

---
 rtl/cordic_exp_ctrl_pkg.sv | 18 +
 rtl/cordic_exp_ctrl_if.sv | 28 ++
 rtl/cordic_iter_counter.sv | 38 +++
 rtl/cordic_exp_ctrl.sv | 156 +++++++++++++++
 tb/tb_cordic_exp_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/cordic_exp_ctrl_pkg.sv
// Shared definitions for the CORDIC exponential controller slice.
//   state_e  : sequencer states (3-bit encoding)
//   ITER_DEF : default number of CORDIC iterations
//   D_DEF    : default ROM address width
package cordic_exp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ITER   = 3'd2,
    ST_RESULT = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int ITER_DEF = 32;
  localparam int D_DEF    = 5;

endpackage

// File: rtl/cordic_exp_ctrl_if.sv
// Handshake and datapath-control bundle of the CORDIC exponential controller.
//   master : requester side (drives BEG_FSM / ACK_FSM, observes everything else)
//   slave  : controller side (samples BEG_FSM / ACK_FSM, drives ROM and
//            datapath enables, BUSY and RDY)
interface cordic_exp_ctrl_if #(
  parameter int D = 5
);
  logic         BEG_FSM;
  logic         ACK_FSM;
  logic         EN_ROM1;
  logic [D-1:0] ADRS;
  logic         LOAD_IN;
  logic         EN_ITER;
  logic [D-1:0] ITER_IDX;
  logic         EN_RES;
  logic         BUSY;
  logic         RDY;

  modport master (
    output BEG_FSM, ACK_FSM,
    input  EN_ROM1, ADRS, LOAD_IN, EN_ITER, ITER_IDX, EN_RES, BUSY, RDY
  );

  modport slave (
    input  BEG_FSM, ACK_FSM,
    output EN_ROM1, ADRS, LOAD_IN, EN_ITER, ITER_IDX, EN_RES, BUSY, RDY
  );
endinterface

// File: rtl/cordic_iter_counter.sv
// Iteration counter k for the CORDIC sequencer.
//   CLK, RST : clock, synchronous active-high reset (clears k)
//   clr      : load k with 0 (takes priority over en)
//   en       : increment k
//   k        : current iteration index
//   tc       : terminal count, high when k = ITER-1
module cordic_iter_counter #(
  parameter int D    = 5,
  parameter int ITER = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         en,
  output logic [D-1:0] k,
  output logic         tc
);

  logic [D-1:0] k_r;

  // iteration index register
  always_ff @(posedge CLK) begin
    if (RST) begin
      k_r <= {D{1'b0}};
    end else if (clr) begin
      k_r <= {D{1'b0}};
    end else if (en) begin
      k_r <= k_r + D'(1'b1);
    end else begin
      k_r <= k_r;
    end
  end

  assign k  = k_r;
  // ITER <= 2^D, so ITER-1 always fits in D bits
  assign tc = (k_r == D'(ITER - 1));

endmodule

// File: rtl/cordic_exp_ctrl.sv
// Sequencer for the CORDIC exponential datapath: start handshake, operand
// load, ITER iterations with one-cycle ROM prefetch, result capture and a
// ready flag held until acknowledged.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : slave side of cordic_exp_ctrl_if
//              (BEG_FSM/ACK_FSM in; EN_ROM1, ADRS, LOAD_IN, EN_ITER,
//               ITER_IDX, EN_RES, BUSY, RDY out, all registered)
module cordic_exp_ctrl
  import cordic_exp_pkg::*;
#(
  parameter int P    = 32,
  parameter int D    = D_DEF,
  parameter int ITER = ITER_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  cordic_exp_ctrl_if.slave   bus
);

  generate
    if (ITER < 2 || ITER > (1 << D)) begin : g_bad_iter
      $error("cordic_exp_ctrl: ITER must satisfy 2 <= ITER <= 2^D");
    end
    if (P < 1) begin : g_bad_p
      $error("cordic_exp_ctrl: ROM word width P must be positive");
    end
  endgenerate

  // ITER at D+1 bits so ITER = 2^D is representable
  localparam logic [D:0] ITER_W = (D+1)'(ITER);

  state_e       state_r;
  logic [D-1:0] k_s;
  logic         tc_s;
  logic         cnt_clr_s;
  logic         cnt_en_s;
  logic [D-1:0] k_inc_s;
  logic [D:0]   k_pf_s;

  logic         en_rom1_r;
  logic [D-1:0] adrs_r;
  logic         load_in_r;
  logic         en_iter_r;
  logic [D-1:0] iter_idx_r;
  logic         en_res_r;
  logic         busy_r;
  logic         rdy_r;

  cordic_iter_counter #(
    .D    (D),
    .ITER (ITER)
  ) u_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (cnt_clr_s),
    .en  (cnt_en_s),
    .k   (k_s),
    .tc  (tc_s)
  );

  // counter control and next-cycle index arithmetic
  always_comb begin
    cnt_clr_s = (state_r == ST_LOAD);
    cnt_en_s  = (state_r == ST_ITER) && !tc_s;
    k_inc_s   = k_s + D'(1'b1);
    // Outputs are registered one cycle ahead, so the address prefetched
    // alongside iteration k+1 is k+2 (i.e. "k+1" of the next cycle).
    k_pf_s    = {1'b0, k_s} + (D+1)'(2'd2);
  end

  // sequencer state and registered Moore outputs for the next state/k
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      en_rom1_r  <= 1'b0;
      adrs_r     <= {D{1'b0}};
      load_in_r  <= 1'b0;
      en_iter_r  <= 1'b0;
      iter_idx_r <= {D{1'b0}};
      en_res_r   <= 1'b0;
      busy_r     <= 1'b0;
      rdy_r      <= 1'b0;
    end else begin
      en_rom1_r  <= 1'b0;
      adrs_r     <= {D{1'b0}};
      load_in_r  <= 1'b0;
      en_iter_r  <= 1'b0;
      iter_idx_r <= {D{1'b0}};
      en_res_r   <= 1'b0;
      busy_r     <= 1'b0;
      rdy_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.BEG_FSM) begin
            state_r   <= ST_LOAD;
            load_in_r <= 1'b1;
            en_rom1_r <= 1'b1;
            busy_r    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          // first iteration k=0; ITER >= 2 so address 1 is always valid
          state_r   <= ST_ITER;
          en_iter_r <= 1'b1;
          en_rom1_r <= 1'b1;
          adrs_r    <= D'(1'b1);
          busy_r    <= 1'b1;
        end
        ST_ITER: begin
          busy_r <= 1'b1;
          if (tc_s) begin
            state_r  <= ST_RESULT;
            en_res_r <= 1'b1;
          end else begin
            state_r    <= ST_ITER;
            en_iter_r  <= 1'b1;
            iter_idx_r <= k_inc_s;
            if (k_pf_s < ITER_W) begin
              en_rom1_r <= 1'b1;
              adrs_r    <= k_pf_s[D-1:0];
            end else begin
              en_rom1_r <= 1'b0;
            end
          end
        end
        ST_RESULT: begin
          state_r <= ST_DONE;
          rdy_r   <= 1'b1;
        end
        ST_DONE: begin
          if (bus.ACK_FSM) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
            rdy_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.EN_ROM1  = en_rom1_r;
  assign bus.ADRS     = adrs_r;
  assign bus.LOAD_IN  = load_in_r;
  assign bus.EN_ITER  = en_iter_r;
  assign bus.ITER_IDX = iter_idx_r;
  assign bus.EN_RES   = en_res_r;
  assign bus.BUSY     = busy_r;
  assign bus.RDY      = rdy_r;

endmodule

// File: tb/tb_cordic_exp_ctrl.sv
// Self-checking bench for cordic_exp_ctrl: one instance with ITER=32 (=2^D)
// and one with ITER=2, each feeding a one-cycle-latency ROM model.
module tb_cordic_exp_ctrl;

  logic CLK;
  logic rst_r;
  logic beg_r;
  logic ack_r;
  logic sel_r;   // 0: ITER=32 instance, 1: ITER=2 instance

  int n_vec;
  int n_err;

  logic [15:0] exp_q[$];

  cordic_exp_ctrl_if #(.D(5)) b32();
  cordic_exp_ctrl_if #(.D(5)) b2();

  assign b32.BEG_FSM = beg_r & ~sel_r;
  assign b32.ACK_FSM = ack_r & ~sel_r;
  assign b2.BEG_FSM  = beg_r & sel_r;
  assign b2.ACK_FSM  = ack_r & sel_r;

  cordic_exp_ctrl #(.P(32), .D(5), .ITER(32)) dut32 (
    .CLK (CLK),
    .RST (rst_r),
    .bus (b32)
  );

  cordic_exp_ctrl #(.P(32), .D(5), .ITER(2)) dut2 (
    .CLK (CLK),
    .RST (rst_r),
    .bus (b2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_tab(logic [4:0] a);
    return 32'hC0DE0000 + ({27'd0, a} * 32'd4099);
  endfunction

  // ROM models: register the table word when enabled, zero otherwise
  logic [31:0] rom32;
  logic [31:0] rom2;
  always @(posedge CLK) begin
    rom32 <= b32.EN_ROM1 ? rom_tab(b32.ADRS) : 32'd0;
    rom2  <= b2.EN_ROM1  ? rom_tab(b2.ADRS)  : 32'd0;
  end

  // {LOAD_IN, EN_ROM1, EN_ITER, EN_RES, BUSY, RDY, ADRS[4:0], ITER_IDX[4:0]}
  logic [15:0] obs32;
  logic [15:0] obs2;
  assign obs32 = {b32.LOAD_IN, b32.EN_ROM1, b32.EN_ITER, b32.EN_RES,
                  b32.BUSY, b32.RDY, b32.ADRS, b32.ITER_IDX};
  assign obs2  = {b2.LOAD_IN, b2.EN_ROM1, b2.EN_ITER, b2.EN_RES,
                  b2.BUSY, b2.RDY, b2.ADRS, b2.ITER_IDX};

  // Expected outputs in cycle c of an operation (cycle 0 = IDLE sampling BEG)
  function automatic logic [15:0] exp_vec(int iter, int c);
    logic       ld, rom, it, res, bsy, rdy;
    logic [4:0] adr, idx;
    int         k;
    ld = 1'b0; rom = 1'b0; it = 1'b0; res = 1'b0; bsy = 1'b0; rdy = 1'b0;
    adr = 5'd0; idx = 5'd0;
    if (c == 1) begin
      ld = 1'b1; rom = 1'b1; bsy = 1'b1;
    end else if (c >= 2 && c <= iter + 1) begin
      k   = c - 2;
      it  = 1'b1;
      bsy = 1'b1;
      idx = 5'(k);
      if (k + 1 < iter) begin
        rom = 1'b1;
        adr = 5'(k + 1);
      end
    end else if (c == iter + 2) begin
      res = 1'b1; bsy = 1'b1;
    end else if (c >= iter + 3) begin
      rdy = 1'b1;
    end
    return {ld, rom, it, res, bsy, rdy, adr, idx};
  endfunction

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare one cycle against the scoreboard, then advance to the next cycle
  task automatic step_check(string tag);
    logic [15:0] o;
    logic [31:0] r;
    @(negedge CLK);
    o = sel_r ? obs2 : obs32;
    r = sel_r ? rom2 : rom32;
    if (exp_q.size() > 0) begin
      check_eq(tag, {16'd0, o}, {16'd0, exp_q.pop_front()});
      if (o[13]) check_eq({tag, "_rom"}, r, rom_tab(o[4:0]));
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_steps(int n, string tag);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(16'd0);
      step_check(tag);
    end
  endtask

  // One full operation starting in the current IDLE cycle; ACK is given in
  // the last of done_wait+1 DONE cycles. hold keeps BEG high throughout.
  task automatic run_op(int iter, bit hold, int done_wait, bit ack_mid, string tag);
    int last;
    last  = iter + 3 + done_wait;
    beg_r = 1'b1;
    for (int c = 0; c <= last; c++) exp_q.push_back(exp_vec(iter, c));
    for (int c = 0; c <= last; c++) begin
      step_check(tag);
      beg_r = hold;
      ack_r = (c + 1 == last) || (ack_mid && (c + 1 == 6));
    end
    ack_r = 1'b0;
  endtask

  // Start an operation, assert RST in the 10th ITER cycle, expect silence
  task automatic abort_op(string tag);
    beg_r = 1'b1;
    for (int c = 0; c <= 11; c++) exp_q.push_back(exp_vec(32, c));
    for (int c = 12; c <= 20; c++) exp_q.push_back(16'd0);
    for (int c = 0; c <= 20; c++) begin
      step_check(tag);
      beg_r = 1'b0;
      rst_r = (c + 1 == 11);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_r = 1'b1;
    beg_r = 1'b0;
    ack_r = 1'b0;
    sel_r = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    rst_r = 1'b0;

    idle_steps(10, "rst_idle");

    run_op(32, 1'b0, 20, 1'b0, "run32_hold_rdy");
    idle_steps(2, "idle_after_ack");

    run_op(32, 1'b0, 0, 1'b1, "run32_ack_in_iter");
    idle_steps(1, "idle_after_ack2");

    // BEG held high: ACK+BEG in DONE, restart from the following IDLE cycle
    run_op(32, 1'b1, 0, 1'b0, "run32_beg_held");
    run_op(32, 1'b0, 1, 1'b0, "run32_back2back");
    idle_steps(2, "idle_after_b2b");

    abort_op("abort");
    run_op(32, 1'b0, 2, 1'b0, "run32_after_abort");
    idle_steps(1, "idle_after_abort");

    sel_r = 1'b1;
    idle_steps(1, "iter2_idle");
    run_op(2, 1'b0, 3, 1'b0, "run_iter2");
    idle_steps(2, "iter2_idle_end");

    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
